// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: CH channels share one timebase, each with double-buffered compares.
// Optional dead-time / complementary outputs enabled by defining PWM_DEADTIME_EN.

module pwm_lane #(
    parameter int CW = 16,
    parameter int DT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CW-1:0] count_val,
    input  logic          wrap,
    input  logic          wr_hit,
    input  logic [1:0]    wr_sel,
    input  logic [CW-1:0] wr_data,
    output logic          pwm_out,
    output logic          pwm_out_n,
    output logic          pending
);
    typedef struct packed {
        logic [2:0]    fn;
        logic [CW-1:0] c2;
        logic [CW-1:0] c1;
    } regs_t;

    regs_t shadow_q, active_q, shadow_nxt, active_nxt, act_base;
    logic  pending_nxt, load, win, raw;

    function automatic regs_t apply_wr(regs_t base, logic [1:0] sel, logic [CW-1:0] data);
        regs_t r;
        r = base;
        case (sel)
            2'd0:    r.c1 = data;
            2'd1:    r.c2 = data;
            2'd2:    r.fn = data[2:0];
            default: r = base;
        endcase
        return r;
    endfunction

    assign load = wrap && pending;

    always_comb begin
        shadow_nxt  = shadow_q;
        active_nxt  = active_q;
        pending_nxt = pending;
        // the load always sees the pre-write shadow; a same-cycle write stays pending
        act_base = load ? shadow_q : active_q;
        active_nxt = act_base;
        if (load)
            pending_nxt = 1'b0;
        if (wr_hit) begin
            shadow_nxt = apply_wr(shadow_q, wr_sel, wr_data);
            if (en)
                pending_nxt = 1'b1;
            else
                active_nxt = apply_wr(act_base, wr_sel, wr_data);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
            pending  <= 1'b0;
        end else begin
            shadow_q <= shadow_nxt;
            active_q <= active_nxt;
            pending  <= pending_nxt;
        end
    end

    always_comb begin
        if (active_q.fn[1])
            win = (active_q.c1 <= count_val) && (count_val < active_q.c2);
        else if (active_q.fn[0])
            win = (count_val >= active_q.c1);
        else
            win = (count_val < active_q.c1);
        raw = en && (win ^ active_q.fn[2]);
    end

`ifdef PWM_DEADTIME_EN
    localparam logic [7:0] DTV = 8'(DT);
    logic [7:0] dt_cnt, dt_nxt;
    logic       raw_q;

    // dt_cnt = number of earlier consecutive cycles raw held its current value (saturating)
    always_comb begin
        if (raw == raw_q)
            dt_nxt = (dt_cnt == DTV) ? DTV : dt_cnt + 8'd1;
        else
            dt_nxt = 8'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            dt_cnt    <= 8'd0;
            raw_q     <= 1'b0;
            pwm_out   <= 1'b0;
            pwm_out_n <= 1'b0;
        end else begin
            dt_cnt    <= dt_nxt;
            raw_q     <= raw;
            pwm_out   <= raw && (dt_nxt >= DTV);
            pwm_out_n <= !raw && (dt_nxt >= DTV);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n)
            pwm_out <= 1'b0;
        else
            pwm_out <= raw;
    end

    assign pwm_out_n = 1'b0;
`endif
endmodule

module pwm_multi_gen #(
    parameter int CH = 4,
    parameter int CW = 16,
    parameter int DT = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [CH-1:0]                     pwm_en,
    input  logic [CW-1:0]                     count_val,
    input  logic [CW-1:0]                     period,
    input  logic                              upnotdown,
    input  logic                              wr_en,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] wr_ch,
    input  logic [1:0]                        wr_sel,
    input  logic [CW-1:0]                     wr_data,
    output logic [CH-1:0]                     pwm_out,
    output logic [CH-1:0]                     pwm_out_n,
    output logic [CH-1:0]                     pending
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    logic wrap;
    assign wrap = upnotdown ? (count_val == period) : (count_val == '0);

    for (genvar i = 0; i < CH; i++) begin : g_lane
        logic wr_hit;
        // channel numbers >= CH never match, so such writes drop out here
        assign wr_hit = wr_en && (wr_ch == CHW'(i)) && (wr_sel != 2'd3);

        pwm_lane #(.CW(CW), .DT(DT)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (pwm_en[i]),
            .count_val (count_val),
            .wrap      (wrap),
            .wr_hit    (wr_hit),
            .wr_sel    (wr_sel),
            .wr_data   (wr_data),
            .pwm_out   (pwm_out[i]),
            .pwm_out_n (pwm_out_n[i]),
            .pending   (pending[i])
        );
    end
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Scoreboard bench for pwm_multi_gen: stimulus pushes expected outputs, a negedge monitor compares.
// Output checks during enabled-channel runs depend on whether PWM_DEADTIME_EN is defined.

module tb_pwm_multi_gen;
`ifdef PWM_DEADTIME_EN
    localparam bit DTB = 1'b1;
`else
    localparam bit DTB = 1'b0;
`endif
    localparam logic [9:0] DT_MP = DTB ? 10'b0000011100 : 10'b0000011111;
    localparam logic [9:0] DT_MN = DTB ? 10'b1110000000 : 10'b0000000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  pwm_en;
    logic [15:0] count_val;
    logic [15:0] period;
    logic        upnotdown;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [1:0]  wr_sel;
    logic [15:0] wr_data;
    logic [3:0]  pwm_out, pwm_out_n, pending;

    pwm_multi_gen #(.CH(4), .CW(16), .DT(2)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_en(pwm_en), .count_val(count_val),
        .period(period), .upnotdown(upnotdown), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_sel(wr_sel), .wr_data(wr_data), .pwm_out(pwm_out),
        .pwm_out_n(pwm_out_n), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        bit         co;
        logic [3:0] p;
        logic [3:0] n;
        logic [3:0] d;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL stale_entry due=%0d cyc=%0d", e.due, cyc);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("pending", pending, e.d);
            chk("overlap", pwm_out & pwm_out_n, 4'b0000);
            if (e.co) begin
                chk("pwm_out", pwm_out, e.p);
                chk("pwm_out_n", pwm_out_n, e.n);
            end
        end
    end

    task automatic step(input logic [15:0] c, input logic [3:0] ep, input logic [3:0] en,
                        input logic [3:0] ed, input bit co);
        exp_t e;
        count_val = c;
        e.due = cyc + 1; e.co = co; e.p = ep; e.n = en; e.d = ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wr(input int ch, input logic [1:0] sel, input logic [15:0] data);
        wr_en = 1'b1;
        wr_ch = 2'(ch);
        wr_sel = sel;
        wr_data = data;
    endtask

    // configuration write with all channels disabled: lands directly in the active copy
    task automatic cfg(input int ch, input logic [1:0] sel, input logic [15:0] data);
        pwm_en = 4'b0000;
        wr(ch, sel, data);
        step(16'd1, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    endtask

    // one full up-count period 0..9; mp/mn/md are per-count expectations for channel ch
    task automatic run_period(input int ch, input logic [9:0] mp, input logic [9:0] mn,
                              input logic [9:0] md, input int wa, input int wb,
                              input logic [1:0] ws, input logic [15:0] da,
                              input logic [15:0] db, input bit co);
        logic [3:0] ep, en, ed;
        pwm_en = 4'b0001 << ch;
        for (int c = 0; c < 10; c++) begin
            ep = '0; en = '0; ed = '0;
            ep[ch] = mp[c];
            en[ch] = mn[c];
            ed[ch] = md[c];
            if (c == wa) wr(ch, ws, da);
            else if (c == wb) wr(ch, ws, db);
            step(16'(c), ep, en, ed, co);
        end
    endtask

    initial begin
        rst_n = 1'b0; pwm_en = '0; count_val = '0; period = 16'd9; upnotdown = 1'b1;
        wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0;
        #1;
        step(16'd0, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        step(16'd0, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        rst_n = 1'b1;

        // left-aligned ch0, compare1=3
        cfg(0, 2'd0, 16'd3);
        run_period(0, 10'b0000000111, 10'b0, 10'b0, -1, -1, 2'd0, 16'd0, 16'd0, !DTB);

        // right-aligned ch0; a wr_sel=3 write must be ignored
        cfg(0, 2'd2, 16'd1);
        run_period(0, 10'b1111111000, 10'b0, 10'b0, 4, -1, 2'd3, 16'd0, 16'd0, !DTB);

        // double buffer ch1: compare1 5 -> 2 mid-period
        cfg(1, 2'd0, 16'd5);
        run_period(1, 10'b0000011111, 10'b0, 10'b0111111000, 3, -1, 2'd0, 16'd2, 16'd0, !DTB);
        run_period(1, 10'b0000000011, 10'b0, 10'b0, -1, -1, 2'd0, 16'd0, 16'd0, !DTB);

        // write on wrap ch2: window 1..c2, c2 written 6 mid-period then 7 on the wrap
        cfg(2, 2'd2, 16'd2);
        cfg(2, 2'd0, 16'd1);
        cfg(2, 2'd1, 16'd4);
        run_period(2, 10'b0000001110, 10'b0, 10'b1111100000, 5, 9, 2'd1, 16'd6, 16'd7, !DTB);
        run_period(2, 10'b0000111110, 10'b0, 10'b0111111111, -1, -1, 2'd1, 16'd0, 16'd0, !DTB);
        run_period(2, 10'b0001111110, 10'b0, 10'b0, -1, -1, 2'd1, 16'd0, 16'd0, !DTB);

        // unaligned + invert ch3, then swapped compares
        cfg(3, 2'd2, 16'd6);
        cfg(3, 2'd0, 16'd2);
        cfg(3, 2'd1, 16'd6);
        run_period(3, 10'b1111000011, 10'b0, 10'b0, -1, -1, 2'd0, 16'd0, 16'd0, !DTB);
        cfg(3, 2'd0, 16'd6);
        cfg(3, 2'd1, 16'd2);
        run_period(3, 10'b1111111111, 10'b0, 10'b0, -1, -1, 2'd0, 16'd0, 16'd0, !DTB);

        // reset mid-run with ch3 output high and a write pending
        pwm_en = 4'b1000;
        step(16'd0, 4'b1000, 4'b0000, 4'b0000, !DTB);
        step(16'd1, 4'b1000, 4'b0000, 4'b0000, !DTB);
        wr(3, 2'd0, 16'd0);
        step(16'd2, 4'b1000, 4'b0000, 4'b1000, !DTB);
        step(16'd3, 4'b1000, 4'b0000, 4'b1000, !DTB);
        rst_n = 1'b0;
        step(16'd4, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        rst_n = 1'b1;
        for (int c = 5; c < 10; c++)
            step(16'(c), 4'b0000, 4'b0000, 4'b0000, !DTB);
        run_period(3, 10'b0, 10'b0, 10'b0, -1, -1, 2'd0, 16'd0, 16'd0, !DTB);

        // left-aligned compare1=5: dead-time gaps when enabled, plain duty otherwise
        cfg(0, 2'd2, 16'd0);
        cfg(0, 2'd0, 16'd5);
        run_period(0, DT_MP, DT_MN, 10'b0, -1, -1, 2'd0, 16'd0, 16'd0, 1'b1);
        run_period(0, DT_MP, DT_MN, 10'b0, -1, -1, 2'd0, 16'd0, 16'd0, 1'b1);

        pwm_en = 4'b0000;
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
